// File: rtl/mem_block_ctrl.sv
// mem_block_ctrl: main-memory stage behind the L1 cache. Serves whole-block
// refills and dirty-victim write-backs with fixed read/write latency and
// holds mem_miss high until the refill block is valid.
module mem_block_ctrl #(
    parameter int BLOCKS        = 8,      // words per cache block, power of 2
    parameter int MEM_WORDS     = 16384,  // backing array depth, multiple of BLOCKS
    parameter int READ_LATENCY  = 4,      // cycles in RD per refill, >= 1
    parameter int WRITE_LATENCY = 4       // cycles in WB per write-back, >= 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_req,
    input  logic [31:0]              mem_read_addr,
    output logic [BLOCKS-1:0][31:0]  mem_read_block,
    input  logic                     mem_we,
    input  logic [31:0]              mem_write_addr,
    input  logic [BLOCKS-1:0][31:0]  mem_write_block,
    output logic                     mem_miss
);

    localparam int IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] RD_START = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_START = CNT_W'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WB,
        RD,
        DONE
    } state_t;

    typedef logic [BLOCKS-1:0][31:0] block_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] rd_base_q;
    logic [IDX_W-1:0] wr_base_q;
    block_t           wr_data_q;
    block_t           rdata_q;
    logic             wb_commit;

    logic [31:0] mem_q [MEM_WORDS];

    // Block base word: word address with the offset cleared, wrapped into the
    // array. Because MEM_WORDS is a multiple of BLOCKS the result stays aligned,
    // so base + i never leaves the array.
    function automatic logic [IDX_W-1:0] block_base(input logic [31:0] addr);
        logic [29:0] word;
        word = 30'(addr >> 2) & ~30'(BLOCKS - 1);
        return IDX_W'(word % 30'(MEM_WORDS));
    endfunction

    // The victim is written on the final WB cycle only while the request is
    // still held; a dropped request or a reset abandons it.
    assign wb_commit = !reset && mem_req && (state_q == WB) && (cnt_q == '0);

    assign mem_miss       = mem_req && (state_q != DONE);
    assign mem_read_block = rdata_q;

    // Request sequencer: latch the transaction, count out WB/RD, present DONE.
    // NOTE: every register here is assigned with <= so all of them see the
    // pre-edge values of each other; blocking writes would create ordering bugs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_base_q <= '0;
            wr_base_q <= '0;
            wr_data_q <= '0;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_req) begin
                        rd_base_q <= block_base(mem_read_addr);
                        wr_base_q <= block_base(mem_write_addr);
                        wr_data_q <= mem_write_block;
                        if (mem_we) begin
                            state_q <= WB;
                            cnt_q   <= WR_START;
                        end else begin
                            state_q <= RD;
                            cnt_q   <= RD_START;
                        end
                    end
                end
                WB: begin
                    if (!mem_req) begin
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= RD;
                        cnt_q   <= RD_START;
                    end
                end
                RD: begin
                    if (!mem_req) begin
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        for (int i = 0; i < BLOCKS; i++) begin
                            rdata_q[i] <= mem_q[rd_base_q + IDX_W'(i)];
                        end
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // The victim still looks dirty this cycle, so the request
                    // inputs are deliberately ignored.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Backing array: commit the latched victim block on the last WB cycle.
    // NOTE: the array has no reset; clearing it would need a multi-cycle sweep,
    // and a real memory keeps its contents across a controller reset.
    always_ff @(posedge clock) begin
        if (wb_commit) begin
            for (int i = 0; i < BLOCKS; i++) begin
                mem_q[wr_base_q + IDX_W'(i)] <= wr_data_q[i];
            end
        end
    end

endmodule

// File: tb/tb_mem_block_ctrl.sv
// Self-checking bench for mem_block_ctrl. Unit 0 uses the default latencies
// (4/4, 16384 words); unit 1 uses 1/1 latency over a 64-word array.
module tb_mem_block_ctrl;

    localparam int BLOCKS = 8;
    typedef logic [BLOCKS-1:0][31:0] blk_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst   [2];
    logic        req   [2];
    logic        we    [2];
    logic [31:0] raddr [2];
    logic [31:0] waddr [2];
    blk_t        wblk  [2];
    blk_t        rblk  [2];
    logic        miss  [2];

    // Per-unit configuration and expectations.
    int   rlat   [2] = '{4, 1};
    int   wlat   [2] = '{4, 1};
    int   mwords [2] = '{16384, 64};
    logic exp_miss  [2];
    logic exp_valid [2];
    blk_t exp_block [2];
    bit   chk_on = 1'b0;

    // Reference memory contents, one image per unit.
    logic [31:0] model [2][16384];

    int total = 0;
    int bad   = 0;

    mem_block_ctrl dut (
        .clock           (clock),
        .reset           (rst[0]),
        .mem_req         (req[0]),
        .mem_read_addr   (raddr[0]),
        .mem_read_block  (rblk[0]),
        .mem_we          (we[0]),
        .mem_write_addr  (waddr[0]),
        .mem_write_block (wblk[0]),
        .mem_miss        (miss[0])
    );

    mem_block_ctrl #(
        .BLOCKS        (BLOCKS),
        .MEM_WORDS     (64),
        .READ_LATENCY  (1),
        .WRITE_LATENCY (1)
    ) dut_fast (
        .clock           (clock),
        .reset           (rst[1]),
        .mem_req         (req[1]),
        .mem_read_addr   (raddr[1]),
        .mem_read_block  (rblk[1]),
        .mem_we          (we[1]),
        .mem_write_addr  (waddr[1]),
        .mem_write_block (wblk[1]),
        .mem_miss        (miss[1])
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic blk_t mk(input logic [31:0] b);
        blk_t r;
        for (int i = 0; i < BLOCKS; i++) r[i] = b + 32'(i);
        return r;
    endfunction

    function automatic int base_of(input logic [31:0] a, input int words);
        return int'((a >> 2) & ~32'(BLOCKS - 1)) % words;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One full transaction starting in the next cycle; returns in the DONE cycle.
    // The expected response is derived from the memory image and latency rules.
    task automatic run_txn(input int u, input logic [31:0] ra, input logic w,
                           input logic [31:0] wa, input blk_t wb);
        int   n;
        int   vb;
        int   rb;
        blk_t e;
        n = 1 + (w ? wlat[u] : 0) + rlat[u];
        if (w) begin
            vb = base_of(wa, mwords[u]);
            for (int i = 0; i < BLOCKS; i++) model[u][vb + i] = wb[i];
        end
        rb = base_of(ra, mwords[u]);
        for (int i = 0; i < BLOCKS; i++) e[i] = model[u][rb + i];
        for (int k = 0; k <= n; k++) begin
            step();
            rst[u]       = 1'b0;
            req[u]       = 1'b1;
            we[u]        = w;
            raddr[u]     = ra;
            waddr[u]     = wa;
            wblk[u]      = wb;
            exp_miss[u]  = (k < n);
            exp_valid[u] = (k == n);
            exp_block[u] = e;
        end
    endtask

    task automatic idle(input int u, input int c);
        repeat (c) begin
            step();
            rst[u]       = 1'b0;
            req[u]       = 1'b0;
            we[u]        = 1'b0;
            exp_miss[u]  = 1'b0;
            exp_valid[u] = 1'b0;
        end
    endtask

    // Start a write-back to 0x3000 that is cut short in its second WB cycle.
    task automatic start_wb_3000(input blk_t d);
        step();
        req[0]       = 1'b1;
        we[0]        = 1'b1;
        waddr[0]     = 32'h0000_3000;
        wblk[0]      = d;
        raddr[0]     = 32'h0000_3000;
        exp_miss[0]  = 1'b1;
        exp_valid[0] = 1'b0;
        step();
        step();
    endtask

    // Every cycle: mem_miss always, mem_read_block in DONE.
    always @(negedge clock) begin
        if (chk_on) begin
            for (int u = 0; u < 2; u++) begin
                check($sformatf("miss u%0d t=%0t", u, $time), 256'(miss[u]), 256'(exp_miss[u]));
                if (exp_valid[u])
                    check($sformatf("block u%0d t=%0t", u, $time), rblk[u], exp_block[u]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; req[u] = 1'b0; we[u] = 1'b0;
            raddr[u] = '0; waddr[u] = '0; wblk[u] = '0;
            exp_miss[u] = 1'b0; exp_valid[u] = 1'b0; exp_block[u] = '0;
            for (int i = 0; i < 16384; i++) model[u][i] = '0;
        end

        step();
        chk_on = 1'b1;
        // Reset held with a request: mem_miss follows mem_req, request not taken.
        req[0] = 1'b1; we[0] = 1'b1; exp_miss[0] = 1'b1;
        step();

        // Preload through write-backs; same-block refill returns the victim data.
        run_txn(0, 32'h0000_0100, 1'b1, 32'h0000_0100, mk(32'h40));
        check("wb-then-rd same block", rblk[0], mk(32'h40));
        run_txn(0, 32'h0000_0020, 1'b1, 32'h0000_0020, mk(32'h80));
        run_txn(0, 32'h0000_0100, 1'b1, 32'h0000_0040, mk(32'hC0));
        idle(0, 1);

        // Clean refill of 0x104: 5 miss cycles, then words 0x40+i.
        run_txn(0, 32'h0000_0104, 1'b0, '0, '0);
        check("clean refill word0", 256'(rblk[0][0]), 256'(32'h40));
        check("clean refill word7", 256'(rblk[0][7]), 256'(32'h47));
        idle(0, 1);

        // Dirty refill with unaligned victim, then back-to-back clean refill
        // of the victim block while mem_we was still high in DONE.
        run_txn(0, 32'h0000_0040, 1'b1, 32'h0000_200C, mk(32'hA0));
        check("dirty refill data", rblk[0], mk(32'hC0));
        run_txn(0, 32'h0000_2000, 1'b0, '0, '0);
        check("victim readback", rblk[0], mk(32'hA0));
        idle(0, 2);

        // Address wrap: 0x0001_0020 aliases word 8.
        run_txn(0, 32'h0001_0020, 1'b0, '0, '0);
        check("wrap refill", rblk[0], mk(32'h80));
        run_txn(0, 32'h0000_0020, 1'b0, '0, '0);
        check("unwrapped refill", rblk[0], mk(32'h80));
        idle(0, 1);

        // Reset mid-WB: block 0x3000 keeps its old (zero) contents.
        run_txn(0, 32'h0000_3000, 1'b1, 32'h0000_3000, '0);
        idle(0, 1);
        start_wb_3000(mk(32'hDEAD_0000));
        rst[0] = 1'b1;
        run_txn(0, 32'h0000_3000, 1'b0, '0, '0);
        check("reset mid-WB discards", rblk[0], blk_t'('0));
        idle(0, 1);

        // Request dropped mid-WB: write not committed.
        start_wb_3000(mk(32'h55));
        req[0] = 1'b0; exp_miss[0] = 1'b0;
        run_txn(0, 32'h0000_3000, 1'b0, '0, '0);
        check("dropped WB discards", rblk[0], blk_t'('0));
        idle(0, 1);

        // Minimum latency unit: dirty 3 cycles, clean 2 cycles, wrap at 64 words.
        idle(1, 1);
        run_txn(1, 32'h0000_0080, 1'b1, 32'h0000_0080, mk(32'h1000));
        idle(1, 1);
        run_txn(1, 32'h0000_0080, 1'b0, '0, '0);
        check("fast clean refill", rblk[1], mk(32'h1000));
        run_txn(1, 32'h0000_0080, 1'b1, 32'h0000_0000, mk(32'h2000));
        run_txn(1, 32'h0000_0100, 1'b0, '0, '0);
        check("fast wrap refill", rblk[1], mk(32'h2000));
        idle(1, 2);
        idle(0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_block_ctrl.md
Name: mem_block_ctrl

Overview:
- Next-level memory stage directly downstream of the L1 cache_module; serves whole-block refills and dirty-victim write-backs over the cache's two-port mem_* interface.
- Models main memory with fixed, parameterised read and write latency.
- Holds mem_miss high until the refill block is valid. The cache stalls and keeps its request stable until then.

Parameters:
- BLOCKS, 8, words per cache block; must be a power of 2 and match the cache.
- MEM_WORDS, 16384, backing array depth in 32-bit words (64 KiB); must be a multiple of BLOCKS.
- READ_LATENCY, 4, cycles spent in RD state per refill; minimum 1.
- WRITE_LATENCY, 4, cycles spent in WB state per write-back; minimum 1.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- mem_req  in  1  cache refill request; held high by the cache until the DONE cycle.
- mem_read_addr  in  32  refill byte address; offset bits [log2(BLOCKS)+1:0] are ignored.
- mem_read_block  out  BLOCKS*32  refill data, packed [BLOCKS-1:0][31:0], word 0 at the block base.
- mem_we  in  1  victim is dirty; sampled only in IDLE together with mem_req.
- mem_write_addr  in  32  victim byte address; may carry a nonzero word offset, which the block masks off.
- mem_write_block  in  BLOCKS*32  victim data; captured in IDLE.
- mem_miss  out  1  combinational: mem_req & (state != DONE).

Behaviour:
- Addressing:
  - Block base word index = addr[31:2] with the low log2(BLOCKS) bits cleared, then taken modulo MEM_WORDS (upper bits dropped).
  - Block word i maps to array entry base + i.
- State machine: IDLE, WB, RD, DONE; down-counter cnt sized to max(READ_LATENCY, WRITE_LATENCY).
- IDLE:
  - If mem_req is high: latch read base, write base and write block.
  - If mem_we is also high: go to WB with cnt = WRITE_LATENCY-1; otherwise go to RD with cnt = READ_LATENCY-1.
  - If mem_req is low: stay in IDLE.
- WB:
  - While cnt != 0: decrement cnt.
  - When cnt == 0: write all BLOCKS latched words into the array at this edge, then go to RD with cnt = READ_LATENCY-1.
- RD:
  - While cnt != 0: decrement cnt.
  - When cnt == 0: load the data register from the array at the latched read base, go to DONE.
  - Write-back to refill ordering: a refill of the same block as the just-written victim returns the written data.
- DONE:
  - mem_miss is low for exactly one cycle and mem_read_block is valid; the cache fills at this edge.
  - Always returns to IDLE. mem_we and mem_req are ignored in DONE, because the victim still looks dirty during this cycle.
- mem_read_block:
  - Registered; holds the last fetched block outside DONE.
  - The bench checks it only in DONE.
- Latency, measured from the first cycle mem_req is high:
  - Clean miss: mem_miss high for 1+READ_LATENCY cycles; DONE on cycle 1+READ_LATENCY.
  - Dirty miss: mem_miss high for 1+WRITE_LATENCY+READ_LATENCY cycles.
- Back-to-back requests:
  - A new mem_req in the cycle after DONE is accepted from IDLE normally.
  - Minimum spacing between refills is one IDLE cycle.
- mem_req dropping in WB or RD (protocol violation): return to IDLE at the next edge and abandon the operation.
  - If it drops in WB before the cnt==0 edge, the write is not committed.
- Reset:
  - state=IDLE, cnt=0, data register=0, latched addresses and data=0.
  - mem_miss = mem_req while reset is held, since state is IDLE.
  - Reset mid-WB before the commit edge discards the write-back; reset mid-RD discards the refill.
  - Array contents are not reset; they initialise to zero at simulation start.
- Simultaneous reset and mem_req: reset wins; the request is sampled in the first IDLE cycle after reset is released.

Test Plan:
- Clean refill: after reset, mem_req=1, mem_we=0, mem_read_addr=0x0000_0104 (block base word 0x40, array words preloaded 0x40+i) -> mem_miss high for 5 cycles; on cycle 5 mem_miss=0 and mem_read_block[i]=0x40+i.
- Dirty refill with unaligned victim: mem_we=1, mem_write_addr=0x0000_200C, write block words 0xA0+i, read addr 0x0000_0040 -> mem_miss high for 9 cycles, DONE on cycle 9; a later clean refill of 0x0000_2000 returns 0xA0+i.
- Back-to-back misses: second mem_req asserted in the cycle right after DONE -> accepted in IDLE; second DONE exactly 1+READ_LATENCY cycles later; mem_we high during the first DONE is ignored, so no extra write-back.
- Reset mid-WB: reset asserted during the 2nd WB cycle of a write-back to 0x0000_3000 -> state IDLE next cycle; a subsequent refill of 0x0000_3000 returns the old contents (zeros).
- Latency sweep: READ_LATENCY=1, WRITE_LATENCY=1 -> clean miss high for 2 cycles, dirty miss high for 3 cycles, data correct.
- Address wrap: mem_read_addr=0x0001_0020 with MEM_WORDS=16384 -> returns the block at word 0x8, equal to a refill of 0x0000_0020.
